// File: rtl/conva1_stream_ctrl_pkg.sv
// Shared types and sizing helpers for the ConvA1 stream controller.
package conva1_stream_ctrl_pkg;

  // Two cycles after the last IFM read drain the push and window-tag pipeline.
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_WM = 3'd1,
    S_STREAM  = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Counter width for a range of n values (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of valid convolution windows per filter.
  function automatic int win_count(input int ifm_size, input int kernal_size);
    return (ifm_size - kernal_size + 1) * (ifm_size - kernal_size + 1);
  endfunction

  // Cycles spent on one filter: weight load, raster stream, drain.
  function automatic int filter_cycles(input int ifm_size, input int kernal_size);
    return kernal_size * kernal_size + ifm_size * ifm_size + DRAIN_CYCLES;
  endfunction

endpackage

// File: rtl/conva1_stream_ctrl_raster_counter.sv
// Row/column/linear raster counter. Saturates on the last position;
// returning to 0 only happens through i_clear.
module conva1_stream_ctrl_raster_counter
  import conva1_stream_ctrl_pkg::*;
#(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int ROW_W = cnt_w(ROWS),
  parameter int COL_W = cnt_w(COLS),
  parameter int LIN_W = cnt_w(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic [LIN_W-1:0] o_lin,
  output logic             o_last
);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [LIN_W-1:0] r_lin;
  logic             w_col_end;
  logic             w_last;

  assign w_col_end = (r_col == COL_W'(COLS - 1));
  assign w_last    = w_col_end && (r_row == ROW_W'(ROWS - 1));

  // Advance in raster order; hold at the final position until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_lin <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
      r_lin <= '0;
    end else if (i_enable && !w_last) begin
      r_lin <= r_lin + 1'b1;
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_lin  = r_lin;
  assign o_last = w_last;

endmodule

// File: rtl/conva1_stream_ctrl.sv
// ConvA1 stream controller: per filter, load KERNAL_SIZE^2 weights into the
// weight FIFO, then stream one IFM channel in raster order into the line
// buffer, flagging every cycle where a complete window has been pushed.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_IDLE    | waiting for start; filter index held at 0
//  S_LOAD_WM | reading weight k of the current filter (k = 0..K^2-1)
//  S_STREAM  | reading IFM pixel p in raster order (p = 0..IFM^2-1)
//  S_DRAIN   | two cycles flushing the push / window-tag pipeline
//  S_DONE    | one-cycle done pulse, then back to idle
module conva1_stream_ctrl
  import conva1_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int IFM_SIZE          = 32,
  parameter int KERNAL_SIZE       = 5,
  parameter int NUMBER_OF_FILTERS = 6,
  parameter int IFM_SIZE_NEXT     = IFM_SIZE - KERNAL_SIZE + 1,
  parameter int ADDRESS_SIZE_IFM  = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_WM   = $clog2(KERNAL_SIZE * KERNAL_SIZE * NUMBER_OF_FILTERS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [DATA_WIDTH-1:0]                 ifm_data_in,
  output logic [ADDRESS_SIZE_IFM-1:0]           ifm_address,
  output logic                                  ifm_enable_read,
  output logic [ADDRESS_SIZE_WM-1:0]            wm_address,
  output logic                                  wm_enable_read,
  output logic                                  wm_fifo_enable,
  output logic [DATA_WIDTH-1:0]                 unit_data_out,
  output logic                                  fifo_enable,
  output logic                                  conv_enable,
  output logic [cnt_w(NUMBER_OF_FILTERS)-1:0]   filter_index,
  output logic                                  busy,
  output logic                                  done
);

  localparam int KK        = KERNAL_SIZE * KERNAL_SIZE;
  localparam int KR_W      = cnt_w(KERNAL_SIZE);
  localparam int KL_W      = cnt_w(KK);
  localparam int PR_W      = cnt_w(IFM_SIZE);
  localparam int PL_W      = cnt_w(IFM_SIZE * IFM_SIZE);
  localparam int FI_W      = cnt_w(NUMBER_OF_FILTERS);
  // First row/column at which a full window lies inside the IFM.
  localparam int WIN_START = IFM_SIZE - IFM_SIZE_NEXT;

  state_t r_state;
  state_t w_next;

  logic [FI_W-1:0] r_filter_idx;
  logic            r_drain;
  logic            r_wm_rd_d;
  logic            r_ifm_rd_d;
  logic            r_win_d1;
  logic            r_win_d2;

  logic            w_wm_rd;
  logic            w_ifm_rd;
  logic            w_done;
  logic            w_busy;
  logic            w_win;
  logic            w_last_filter;

  // The kernel walk only needs its linear index as the weight offset.
  logic [KR_W-1:0] w_k_row_unused;
  logic [KR_W-1:0] w_k_col_unused;
  logic [KL_W-1:0] w_k_lin;
  logic            w_k_last;

  logic [PR_W-1:0] w_p_row;
  logic [PR_W-1:0] w_p_col;
  logic [PL_W-1:0] w_p_lin;
  logic            w_p_last;

  logic [ADDRESS_SIZE_WM-1:0] w_wm_addr;

  conva1_stream_ctrl_raster_counter #(
    .ROWS (KERNAL_SIZE),
    .COLS (KERNAL_SIZE)
  ) u_k_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .i_clear  (r_state != S_LOAD_WM),
    .i_enable (w_wm_rd),
    .o_row    (w_k_row_unused),
    .o_col    (w_k_col_unused),
    .o_lin    (w_k_lin),
    .o_last   (w_k_last)
  );

  conva1_stream_ctrl_raster_counter #(
    .ROWS (IFM_SIZE),
    .COLS (IFM_SIZE)
  ) u_p_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .i_clear  (r_state != S_STREAM),
    .i_enable (w_ifm_rd),
    .o_row    (w_p_row),
    .o_col    (w_p_col),
    .o_lin    (w_p_lin),
    .o_last   (w_p_last)
  );

  assign w_last_filter = (r_filter_idx == FI_W'(NUMBER_OF_FILTERS - 1));
  assign w_win = w_ifm_rd && (w_p_row >= PR_W'(WIN_START)) && (w_p_col >= PR_W'(WIN_START));
  assign w_wm_addr = ADDRESS_SIZE_WM'(r_filter_idx) * ADDRESS_SIZE_WM'(KK)
                   + ADDRESS_SIZE_WM'(w_k_lin);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    w_next   = r_state;
    w_wm_rd  = 1'b0;
    w_ifm_rd = 1'b0;
    w_done   = 1'b0;
    w_busy   = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = S_LOAD_WM;
      end
      S_LOAD_WM: begin
        w_wm_rd = 1'b1;
        if (w_k_last) w_next = S_STREAM;
      end
      S_STREAM: begin
        w_ifm_rd = 1'b1;
        if (w_p_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain) w_next = w_last_filter ? S_DONE : S_LOAD_WM;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Drain cycle marker and filter index; the index only moves on the
  // second drain cycle and is forced back to 0 while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drain      <= 1'b0;
      r_filter_idx <= '0;
    end else begin
      r_drain <= (r_state == S_DRAIN) && !r_drain;
      if (r_state == S_IDLE) begin
        r_filter_idx <= '0;
      end else if ((r_state == S_DRAIN) && r_drain && !w_last_filter) begin
        r_filter_idx <= r_filter_idx + 1'b1;
      end
    end
  end

  // Memory read data lands one cycle after the strobe, so pushes follow the
  // reads by one cycle and the window tag rides one stage further.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wm_rd_d  <= 1'b0;
      r_ifm_rd_d <= 1'b0;
      r_win_d1   <= 1'b0;
      r_win_d2   <= 1'b0;
    end else begin
      r_wm_rd_d  <= w_wm_rd;
      r_ifm_rd_d <= w_ifm_rd;
      r_win_d1   <= w_win;
      r_win_d2   <= r_win_d1;
    end
  end

  assign wm_enable_read  = w_wm_rd;
  assign wm_address      = w_wm_rd ? w_wm_addr : '0;
  assign wm_fifo_enable  = r_wm_rd_d;
  assign ifm_enable_read = w_ifm_rd;
  assign ifm_address     = w_ifm_rd ? ADDRESS_SIZE_IFM'(w_p_lin) : '0;
  assign fifo_enable     = r_ifm_rd_d;
  assign conv_enable     = r_win_d2;
  assign unit_data_out   = ifm_data_in;
  assign filter_index    = r_filter_idx;
  assign busy            = w_busy;
  assign done            = w_done;

endmodule

// File: tb/tb_conva1_stream_ctrl.sv
// Scoreboard bench for conva1_stream_ctrl: default-size instance plus a
// reduced instance (IFM 6, kernel 3, 2 filters).
module tb_conva1_stream_ctrl;

  localparam int IFM  = 32;
  localparam int K    = 5;
  localparam int NF   = 6;
  localparam int KK   = 25;
  localparam int NPIX = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        s_start;
  int          cyc = 0;

  logic [31:0] ifm_data_in = '0;
  logic [9:0]  ifm_address;
  logic        ifm_enable_read;
  logic [7:0]  wm_address;
  logic        wm_enable_read;
  logic        wm_fifo_enable;
  logic [31:0] unit_data_out;
  logic        fifo_enable;
  logic        conv_enable;
  logic [2:0]  filter_index;
  logic        busy;
  logic        done;

  logic [31:0] s_ifm_data_in = '0;
  logic [5:0]  s_ifm_address;
  logic        s_ifm_enable_read;
  logic [4:0]  s_wm_address;
  logic        s_wm_enable_read;
  logic        s_wm_fifo_enable;
  logic [31:0] s_unit_data_out;
  logic        s_fifo_enable;
  logic        s_conv_enable;
  logic [0:0]  s_filter_index;
  logic        s_busy;
  logic        s_done;

  always #5 clk = ~clk;

  conva1_stream_ctrl u_dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .ifm_data_in     (ifm_data_in),
    .ifm_address     (ifm_address),
    .ifm_enable_read (ifm_enable_read),
    .wm_address      (wm_address),
    .wm_enable_read  (wm_enable_read),
    .wm_fifo_enable  (wm_fifo_enable),
    .unit_data_out   (unit_data_out),
    .fifo_enable     (fifo_enable),
    .conv_enable     (conv_enable),
    .filter_index    (filter_index),
    .busy            (busy),
    .done            (done)
  );

  conva1_stream_ctrl #(
    .IFM_SIZE          (6),
    .KERNAL_SIZE       (3),
    .NUMBER_OF_FILTERS (2)
  ) u_small (
    .clk             (clk),
    .reset           (reset),
    .start           (s_start),
    .ifm_data_in     (s_ifm_data_in),
    .ifm_address     (s_ifm_address),
    .ifm_enable_read (s_ifm_enable_read),
    .wm_address      (s_wm_address),
    .wm_enable_read  (s_wm_enable_read),
    .wm_fifo_enable  (s_wm_fifo_enable),
    .unit_data_out   (s_unit_data_out),
    .fifo_enable     (s_fifo_enable),
    .conv_enable     (s_conv_enable),
    .filter_index    (s_filter_index),
    .busy            (s_busy),
    .done            (s_done)
  );

  // Pixel word stored at IFM address a; low half carries the address tag.
  function automatic logic [31:0] pix(input int a);
    logic [31:0] v;
    v = a;
    return 32'hC0DE_0000 | {16'h0000, v[15:0]};
  endfunction

  // IFM memory models: read data valid one cycle after the strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifm_enable_read)   ifm_data_in   <= pix(int'(ifm_address));
    if (s_ifm_enable_read) s_ifm_data_in <= pix(int'(s_ifm_address));
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint outs_main();
    return longint'({busy, done, wm_enable_read, wm_fifo_enable, ifm_enable_read,
                     fifo_enable, conv_enable, filter_index, wm_address, ifm_address});
  endfunction

  // Scoreboard queues for the default instance.
  int          q_wm_addr[$];
  int          q_wm_fi[$];
  logic [31:0] q_pix[$];
  int          q_conv[$];
  int          q_ord[$];
  int          q_done[$];
  int          q_cnt[$];
  // Scoreboard queues for the reduced instance.
  int          s_q_done[$];
  int          s_q_cnt[$];

  task automatic push_full_run(input int acc);
    for (int f = 0; f < NF; f++) begin
      for (int k = 0; k < KK; k++) begin
        q_wm_addr.push_back(f * KK + k);
        q_wm_fi.push_back(f);
      end
      q_ord.push_back(KK * (f + 1));
      for (int p = 0; p < NPIX; p++) q_pix.push_back(pix(p));
      for (int r = 0; r < IFM; r++)
        for (int c = 0; c < IFM; c++)
          if (r >= K - 1 && c >= K - 1) q_conv.push_back(r * IFM + c);
    end
    // 6 filters x (25 + 1024 + 2) cycles, done on the following cycle.
    q_done.push_back(acc + 6306);
    q_cnt.push_back(150);
    q_cnt.push_back(6144);
    q_cnt.push_back(4704);
  endtask

  // Monitor for the default instance.
  int wm_pushes = 0;
  int pix_pushes = 0;
  int conv_cnt = 0;
  int last_tag = -1;

  always @(negedge clk) begin
    if (!reset) begin
      wm_pushes  = 0;
      pix_pushes = 0;
      conv_cnt   = 0;
    end else begin
      if (wm_enable_read) begin
        if (q_wm_addr.size() == 0) chk("wm_read_unexpected", 1, 0);
        else begin
          chk("wm_address", longint'(wm_address), longint'(q_wm_addr.pop_front()));
          chk("filter_index", longint'(filter_index), longint'(q_wm_fi.pop_front()));
        end
      end
      if (wm_fifo_enable) wm_pushes++;
      if (conv_enable) begin
        conv_cnt++;
        if (q_conv.size() == 0) chk("conv_unexpected", 1, 0);
        else chk("conv_window_tag", longint'(last_tag), longint'(q_conv.pop_front()));
      end
      if (fifo_enable) begin
        if (pix_pushes % NPIX == 0) begin
          if (q_ord.size() == 0) chk("order_unexpected", 1, 0);
          else chk("weights_before_pixels", longint'(wm_pushes), longint'(q_ord.pop_front()));
        end
        pix_pushes++;
        if (q_pix.size() == 0) chk("pixel_unexpected", 1, 0);
        else chk("unit_data_out", longint'(unit_data_out), longint'(q_pix.pop_front()));
        last_tag = int'(unit_data_out[15:0]);
      end
      if (done) begin
        if (q_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          chk("done_cycle", longint'(cyc), longint'(q_done.pop_front()));
          chk("busy_at_done", longint'(busy), 1);
          chk("wm_push_count", longint'(wm_pushes), longint'(q_cnt.pop_front()));
          chk("pixel_push_count", longint'(pix_pushes), longint'(q_cnt.pop_front()));
          chk("conv_count", longint'(conv_cnt), longint'(q_cnt.pop_front()));
          chk("queues_drained", longint'(q_wm_addr.size() + q_pix.size() + q_conv.size()), 0);
        end
        wm_pushes  = 0;
        pix_pushes = 0;
        conv_cnt   = 0;
      end
    end
  end

  // Monitor for the reduced instance.
  int s_wm_reads = 0;
  int s_wm_pushes = 0;
  int s_pix = 0;
  int s_conv = 0;

  always @(negedge clk) begin
    if (!reset) begin
      s_wm_reads  = 0;
      s_wm_pushes = 0;
      s_pix       = 0;
      s_conv      = 0;
    end else begin
      if (s_wm_enable_read) begin
        chk("s_wm_address", longint'(s_wm_address), longint'(s_wm_reads));
        chk("s_filter_index", longint'(s_filter_index), longint'(s_wm_reads / 9));
        s_wm_reads++;
      end
      if (s_wm_fifo_enable) s_wm_pushes++;
      if (s_conv_enable) s_conv++;
      if (s_fifo_enable) begin
        chk("s_unit_data_out", longint'(s_unit_data_out), longint'(pix(s_pix % 36)));
        s_pix++;
      end
      if (s_done) begin
        if (s_q_done.size() == 0) chk("s_done_unexpected", 1, 0);
        else begin
          chk("s_done_cycle", longint'(cyc), longint'(s_q_done.pop_front()));
          chk("s_busy_at_done", longint'(s_busy), 1);
          chk("s_wm_push_count", longint'(s_wm_pushes), longint'(s_q_cnt.pop_front()));
          chk("s_pixel_push_count", longint'(s_pix), longint'(s_q_cnt.pop_front()));
          chk("s_conv_count", longint'(s_conv), longint'(s_q_cnt.pop_front()));
        end
        s_wm_reads  = 0;
        s_wm_pushes = 0;
        s_pix       = 0;
        s_conv      = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_main_done(input string name);
    int i;
    i = 0;
    while (q_done.size() != 0 && i < 7000) begin
      tick(1);
      i++;
    end
    chk(name, longint'(q_done.size()), 0);
  endtask

  initial begin
    int acc;
    reset   = 1'b0;
    start   = 1'b0;
    s_start = 1'b0;
    tick(3);

    // Start while held in reset must do nothing.
    start   = 1'b1;
    s_start = 1'b1;
    tick(1);
    start   = 1'b0;
    s_start = 1'b0;
    chk("reset_outputs_zero", outs_main(), 0);
    chk("reset_small_busy", longint'(s_busy), 0);

    // Idle with no start.
    reset = 1'b1;
    tick(100);
    chk("idle_outputs_zero", outs_main(), 0);
    chk("idle_small_busy", longint'(s_busy), 0);

    // Reduced instance: 2 filters x (9 + 36 + 2) cycles.
    acc = cyc + 1;
    s_q_done.push_back(acc + 94);
    s_q_cnt.push_back(18);
    s_q_cnt.push_back(72);
    s_q_cnt.push_back(32);
    s_start = 1'b1;
    tick(1);
    s_start = 1'b0;
    for (int i = 0; i < 200 && s_q_done.size() != 0; i++) tick(1);
    chk("small_run_completed", longint'(s_q_done.size()), 0);
    tick(5);

    // Full run with an ignored start pulse during STREAM.
    acc = cyc + 1;
    push_full_run(acc);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(300);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_main_done("run1_completed");
    tick(5);
    chk("post_run_idle", outs_main(), 0);

    // Reset 500 cycles into a run: everything drops at once, no done.
    acc = cyc + 1;
    push_full_run(acc);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(499);
    reset = 1'b0;
    #1;
    chk("abort_outputs_zero", outs_main(), 0);
    tick(3);
    q_wm_addr.delete();
    q_wm_fi.delete();
    q_pix.delete();
    q_conv.delete();
    q_ord.delete();
    q_done.delete();
    q_cnt.delete();
    reset = 1'b1;
    tick(20);
    chk("abort_stays_idle", outs_main(), 0);

    // Fresh run after the abort gives full counts again.
    acc = cyc + 1;
    push_full_run(acc);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_main_done("run2_completed");
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conva1_stream_ctrl.md
Name: conva1_stream_ctrl

Overview:
- Sequencer and transmitter that feeds one ConvA1 convolution unit.
- For each filter it reads that filter's KERNAL_SIZE² weights from the unit's weight memory into the weight FIFO.
- It then streams one IFM channel from the IFM memory in raster order into the unit's line-buffer FIFO, asserting conv_enable on every cycle where a full valid window is present.
- It sits between the IFM memory and the unit: one instance per unit, with channel selection done by the instantiating layer.

Parameters:
- DATA_WIDTH, 32, pixel and weight word width.
- IFM_SIZE, 32, IFM side length.
- KERNAL_SIZE, 5, kernel side length.
- NUMBER_OF_FILTERS, 6, filters processed per run.
- IFM_SIZE_NEXT, IFM_SIZE-KERNAL_SIZE+1, output side length (derived).
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), IFM address width (derived).
- ADDRESS_SIZE_WM, $clog2(KERNAL_SIZE*KERNAL_SIZE*NUMBER_OF_FILTERS), weight address width (derived).

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle run request; sampled only in IDLE.
- ifm_data_in  in  DATA_WIDTH  IFM memory read data, valid 1 cycle after ifm_enable_read.
- ifm_address  out  ADDRESS_SIZE_IFM  IFM read address.
- ifm_enable_read  out  1  IFM memory read strobe.
- wm_address  out  ADDRESS_SIZE_WM  weight memory address.
- wm_enable_read  out  1  weight memory read strobe.
- wm_fifo_enable  out  1  weight FIFO push.
- unit_data_out  out  DATA_WIDTH  pixel to the unit; equals ifm_data_in combinationally.
- fifo_enable  out  1  IFM FIFO push.
- conv_enable  out  1  window valid; the convolution result is produced for this window.
- filter_index  out  $clog2(NUMBER_OF_FILTERS)  filter currently being processed.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse at run end.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; every output and counter goes to 0. Assertion mid-run aborts the run immediately; no done pulse is produced.
- States: IDLE, LOAD_WM, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 moves to LOAD_WM with filter_index=0 and k=0.
  - start in any other state is ignored.
- LOAD_WM:
  - wm_enable_read=1 and wm_address=filter_index*KERNAL_SIZE² + k, with k running 0..KERNAL_SIZE²-1.
  - wm_fifo_enable is wm_enable_read delayed one cycle, giving exactly KERNAL_SIZE² pushes per filter.
  - After k=KERNAL_SIZE²-1, go to STREAM with p=0.
- STREAM:
  - ifm_enable_read=1 and ifm_address=p, with p running 0..IFM_SIZE²-1; row r=p/IFM_SIZE and col c=p%IFM_SIZE are kept as separate counters, not computed by division.
  - fifo_enable is ifm_enable_read delayed one cycle.
  - conv_enable is asserted 2 cycles after the read of p when r≥KERNAL_SIZE-1 and c≥KERNAL_SIZE-1. The tag is pipelined alongside the read.
  - The last weight push and the first IFM read share a cycle; this overlap is legal.
  - After p=IFM_SIZE²-1, go to DRAIN.
- DRAIN:
  - Lasts 2 cycles, long enough to flush the fifo_enable and conv_enable pipeline.
  - Then, if filter_index<NUMBER_OF_FILTERS-1: increment filter_index, go to LOAD_WM. Otherwise go to DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE. filter_index returns to 0 in IDLE.
- Per-filter time: KERNAL_SIZE² + IFM_SIZE² + 2 cycles. At defaults this is 25+1024+2 = 1051 cycles.
- conv_enable count per filter: IFM_SIZE_NEXT² (784 at defaults).
- The controller never pushes fifo_enable and wm_fifo_enable for the same filter out of order: all weights precede all pixels.
- Counters saturate at their terminal values and do not wrap; wrap-around to 0 happens only through a state transition.

Decomposition:
- Shared package (conv_pkg):
  - state enum;
  - localparam functions for derived sizes (window count, per-filter cycle count).
- One natural sub-module, raster_counter: row/col/linear counter with a clear input, an enable input and a last flag. It is instantiated twice, once for k over KERNAL_SIZE×KERNAL_SIZE and once for p over IFM_SIZE×IFM_SIZE.

Test Plan:
- Reset and idle: hold reset=0, pulse start → all outputs 0. Release reset with no start for 100 cycles → busy=0, no strobes.
- Single run at defaults: start pulse → wm_fifo_enable count=150 (6×25), fifo_enable count=6144, conv_enable count=4704. done occurs exactly 1 cycle after the last DRAIN cycle; total 6306 cycles plus the fixed start and done overhead.
- Address sequence: for filter 2, wm_address runs 50..74. For each filter, ifm_address runs 0..1023. unit_data_out equals the memory model's word at the address read one cycle earlier.
- Window alignment: the first conv_enable of each filter appears 2 cycles after the read of p=132 (r=4, c=4); no conv_enable occurs for c<4. The pixel pushed at that point has value tag 132.
- Start while busy and mid-run reset: a start pulse during STREAM is ignored, with totals unchanged. reset=0 at cycle 500 returns all outputs to 0 in the same cycle with no done pulse. A fresh start then produces full counts again.
- Reduced parameters: IFM_SIZE=6, KERNAL_SIZE=3, NUMBER_OF_FILTERS=2 → 9 weight pushes and 36 pixel pushes per filter, 16 conv_enable per filter, 47 cycles per filter.
